// File: rtl/ram_access_sequencer.sv
// ram_access_sequencer
//   Byte-addressed load/store front end for a 32-bit word RAM with a
//   synchronous write port and a registered read port B. One request is
//   handled at a time. Sub-word stores are done by read-modify-write, and
//   loads are lane-extracted and sign/zero-extended before the response.
//
// Ports
//   clock, nReset          clock, asynchronous active-low reset
//   reqValid/reqReady      request handshake (see below)
//   reqWrite, reqFunct3    1=store / 0=load; RV32 funct3 (B,H,W,BU,HU)
//   reqAddress, reqData    byte address (RAM_A_WIDTH+2 bits), store data
//   respValid              one-cycle completion pulse for every request
//   respData, respError    load result (0 for stores/errors); error flag
//   ramWriteAddress/ramDataIn/ramWriteEnable   RAM write port
//   ramReadAddressB/ramDataOutB                RAM read port B (1-cycle)
//   dbgState               current FSM state, for observation only
//
// Handshake: a request transfers on a rising clock edge where
//   reqValid && reqReady. reqReady is high only in IDLE, and request fields
//   are captured on that edge; the requester may change them afterwards.
//
// Build option: MISALIGN_TRAP_EN
//   defined   - misaligned H/W accesses return respError with no RAM access
//   undefined - low address bits are forced to the access alignment
module ram_access_sequencer #(
  parameter int RAM_A_WIDTH = 12
) (
  input  logic                   clock,
  input  logic                   nReset,
  input  logic                   reqValid,
  output logic                   reqReady,
  input  logic                   reqWrite,
  input  logic [2:0]             reqFunct3,
  input  logic [RAM_A_WIDTH+1:0] reqAddress,
  input  logic [31:0]            reqData,
  output logic                   respValid,
  output logic [31:0]            respData,
  output logic                   respError,
  output logic [RAM_A_WIDTH-1:0] ramWriteAddress,
  output logic [31:0]            ramDataIn,
  output logic                   ramWriteEnable,
  output logic [RAM_A_WIDTH-1:0] ramReadAddressB,
  input  logic [31:0]            ramDataOutB,
  output logic [2:0]             dbgState
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_RD_ISSUE   = 3'd1,
    S_RD_CAPTURE = 3'd2,
    S_WRITE      = 3'd3,
    S_RESP       = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic                   write_q, write_d;
  logic [2:0]             funct3_q, funct3_d;
  logic [1:0]             off_q, off_d;
  logic [15:0]            data_q, data_d;      // only B/H stores merge data
  logic [RAM_A_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [RAM_A_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]            wr_data_q, wr_data_d;
  logic                   we_q, we_d;
  logic [31:0]            resp_data_q, resp_data_d;
  logic                   resp_err_q, resp_err_d;

  // Request decode
  logic [1:0]             req_size;
  logic                   req_illegal;
  logic                   req_err;
  logic [1:0]             req_off;
  logic [RAM_A_WIDTH-1:0] req_widx;

  assign req_size    = reqFunct3[1:0];
  assign req_widx    = reqAddress[RAM_A_WIDTH+1:2];
  assign req_illegal = (reqFunct3 == 3'b011) || (reqFunct3 == 3'b110) ||
                       (reqFunct3 == 3'b111) || (reqWrite && reqFunct3[2]);

`ifdef MISALIGN_TRAP_EN
  logic req_misaligned;
  assign req_misaligned = ((req_size == 2'b01) && reqAddress[0]) ||
                          ((req_size == 2'b10) && (reqAddress[1:0] != 2'b00));
  assign req_err = req_illegal || req_misaligned;
  assign req_off = reqAddress[1:0];
`else
  assign req_err = req_illegal;
  assign req_off = (req_size == 2'b10) ? 2'b00 :
                   (req_size == 2'b01) ? {reqAddress[1], 1'b0} :
                                         reqAddress[1:0];
`endif

  // Lane handling on the word returned by read port B
  logic [4:0]  lane_shamt;
  logic [31:0] rd_shifted;
  logic        load_signed;
  logic [31:0] load_val;
  logic [31:0] lane_mask;
  logic [31:0] merged;

  assign lane_shamt  = {off_q, 3'b000};
  assign rd_shifted  = ramDataOutB >> lane_shamt;
  assign load_signed = ~funct3_q[2];
  assign lane_mask   = ((funct3_q[1:0] == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << lane_shamt;
  assign merged      = (ramDataOutB & ~lane_mask) | (({16'h0000, data_q} << lane_shamt) & lane_mask);

  always_comb begin
    load_val = ramDataOutB;
    case (funct3_q[1:0])
      2'b00:   load_val = {{24{load_signed & rd_shifted[7]}}, rd_shifted[7:0]};
      2'b01:   load_val = {{16{load_signed & rd_shifted[15]}}, rd_shifted[15:0]};
      default: load_val = ramDataOutB;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    funct3_d    = funct3_q;
    off_d       = off_q;
    data_d      = data_q;
    rd_addr_d   = rd_addr_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    we_d        = 1'b0;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
    case (state_q)
      S_IDLE: begin
        if (reqValid) begin
          write_d     = reqWrite;
          funct3_d    = reqFunct3;
          off_d       = req_off;
          data_d      = reqData[15:0];
          resp_data_d = 32'h0;
          resp_err_d  = req_err;
          if (req_err) begin
            state_d = S_RESP;
          end else if (reqWrite && (req_size == 2'b10)) begin
            // Full-word store needs no read.
            wr_addr_d = req_widx;
            wr_data_d = reqData;
            we_d      = 1'b1;
            state_d   = S_WRITE;
          end else begin
            rd_addr_d = req_widx;
            state_d   = S_RD_ISSUE;
          end
        end
      end
      S_RD_ISSUE:   state_d = S_RD_CAPTURE;
      S_RD_CAPTURE: begin
        if (write_q) begin
          wr_addr_d = rd_addr_q;
          wr_data_d = merged;
          we_d      = 1'b1;
          state_d   = S_WRITE;
        end else begin
          resp_data_d = load_val;
          state_d     = S_RESP;
        end
      end
      S_WRITE:  state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state_q     <= S_IDLE;
      write_q     <= 1'b0;
      funct3_q    <= 3'b000;
      off_q       <= 2'b00;
      data_q      <= 16'h0;
      rd_addr_q   <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= 32'h0;
      we_q        <= 1'b0;
      resp_data_q <= 32'h0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      funct3_q    <= funct3_d;
      off_q       <= off_d;
      data_q      <= data_d;
      rd_addr_q   <= rd_addr_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      we_q        <= we_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
    end
  end

  assign reqReady        = (state_q == S_IDLE);
  assign respValid       = (state_q == S_RESP);
  assign respData        = respValid ? resp_data_q : 32'h0;
  assign respError       = respValid & resp_err_q;
  assign ramWriteAddress = wr_addr_q;
  assign ramDataIn       = wr_data_q;
  assign ramWriteEnable  = we_q;
  assign ramReadAddressB = rd_addr_q;
  assign dbgState        = state_q;

endmodule
